// File: rtl/id_decode_stage.sv
// id_decode_stage: RV32I instruction decode into the ID/EX pipeline register (DECODE_ILLEGAL_EN adds ex_illegal).
// Latency: one cycle; an instruction accepted at edge N is visible on every ex_* output after edge N.
// Backpressure: in_ready drops on ex_stall or a load-use hazard; flush squashes ID/EX regardless of stall.

module id_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            ex_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [1:0]      ex_ALUop,
  output logic [6:0]      ex_funct7,
  output logic [2:0]      ex_funct3,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_imm,
  output logic [5:0]      ex_ctrl
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic            ex_illegal
`endif
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // ex_ctrl bit order: {Branch, MemtoReg, MemWrite, MemRead, RegWrite, ALUSrc}
  localparam int C_MEMREAD = 2;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] f_rs1;
  logic [4:0] f_rs2;
  logic [4:0] f_rd;
  assign opcode = in_instr[6:0];
  assign f_rd   = in_instr[11:7];
  assign f_rs1  = in_instr[19:15];
  assign f_rs2  = in_instr[24:20];

  // Sign-extended immediates for each format
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};

  // ID/EX pipeline register
  logic            valid_q,  valid_d;
  logic [XLEN-1:0] pc_q,     pc_d;
  logic [1:0]      aluop_q,  aluop_d;
  logic [6:0]      funct7_q, funct7_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      rs1_q,    rs1_d;
  logic [4:0]      rs2_q,    rs2_d;
  logic [4:0]      rd_q,     rd_d;
  logic [XLEN-1:0] imm_q,    imm_d;
  logic [5:0]      ctrl_q,   ctrl_d;
`ifdef DECODE_ILLEGAL_EN
  logic            ill_q,    ill_d;
`endif

  // Decoder outputs
  logic            dec_legal;
  logic [1:0]      dec_aluop;
  logic [5:0]      dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic            dec_uses_rs2;
  logic            hazard;

  // Opcode decode: ALU operation class, control bundle and immediate selection
  always_comb begin
    dec_legal    = 1'b0;
    dec_aluop    = 2'b00;
    dec_ctrl     = 6'b000000;
    dec_imm      = '0;
    dec_uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        dec_legal    = 1'b1;
        dec_aluop    = 2'b10;
        dec_ctrl     = 6'b000010;
        dec_uses_rs2 = 1'b1;
      end
      OP_I: begin
        dec_legal = 1'b1;
        dec_aluop = 2'b11;
        dec_ctrl  = 6'b000011;
        dec_imm   = imm_i;
      end
      OP_LD: begin
        dec_legal = 1'b1;
        dec_aluop = 2'b00;
        dec_ctrl  = 6'b010111;
        dec_imm   = imm_i;
      end
      OP_ST: begin
        dec_legal    = 1'b1;
        dec_aluop    = 2'b00;
        dec_ctrl     = 6'b001001;
        dec_imm      = imm_s;
        dec_uses_rs2 = 1'b1;
      end
      OP_BR: begin
        dec_legal    = 1'b1;
        dec_aluop    = 2'b01;
        dec_ctrl     = 6'b100000;
        dec_imm      = imm_b;
        dec_uses_rs2 = 1'b1;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  // Load-use: a load in ID/EX whose destination feeds the offered instruction costs one bubble
  assign hazard = valid_q && ctrl_q[C_MEMREAD] && (rd_q != 5'd0) && in_valid &&
                  ((rd_q == f_rs1) || (dec_uses_rs2 && (rd_q == f_rs2)));

  assign in_ready = !ex_stall && !hazard;

  // Next ID/EX content: flush > stall hold > hazard bubble > accept > idle bubble
  always_comb begin
    valid_d  = 1'b0;
    pc_d     = '0;
    aluop_d  = 2'b00;
    funct7_d = 7'd0;
    funct3_d = 3'd0;
    rs1_d    = 5'd0;
    rs2_d    = 5'd0;
    rd_d     = 5'd0;
    imm_d    = '0;
    ctrl_d   = 6'b000000;
`ifdef DECODE_ILLEGAL_EN
    ill_d    = 1'b0;
`endif
    if (flush) begin
      // squash: bubble already set by the defaults
    end else if (ex_stall) begin
      valid_d  = valid_q;
      pc_d     = pc_q;
      aluop_d  = aluop_q;
      funct7_d = funct7_q;
      funct3_d = funct3_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      rd_d     = rd_q;
      imm_d    = imm_q;
      ctrl_d   = ctrl_q;
`ifdef DECODE_ILLEGAL_EN
      ill_d    = ill_q;
`endif
    end else if (hazard) begin
      // load-use bubble; the offered instruction stays in IF/ID
    end else if (in_valid && dec_legal) begin
      valid_d  = 1'b1;
      pc_d     = in_pc;
      aluop_d  = dec_aluop;
      funct7_d = in_instr[31:25];
      funct3_d = in_instr[14:12];
      rs1_d    = f_rs1;
      rs2_d    = f_rs2;
      rd_d     = f_rd;
      imm_d    = dec_imm;
      ctrl_d   = dec_ctrl;
    end else if (in_valid) begin
      // unsupported opcode: bubble, optionally tagged with its PC
`ifdef DECODE_ILLEGAL_EN
      ill_d = 1'b1;
      pc_d  = in_pc;
`endif
    end else begin
      // nothing offered: idle bubble
    end
  end

  // ID/EX register with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      aluop_q  <= 2'b00;
      funct7_q <= 7'd0;
      funct3_q <= 3'd0;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      rd_q     <= 5'd0;
      imm_q    <= '0;
      ctrl_q   <= 6'b000000;
`ifdef DECODE_ILLEGAL_EN
      ill_q    <= 1'b0;
`endif
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      aluop_q  <= aluop_d;
      funct7_q <= funct7_d;
      funct3_q <= funct3_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      ctrl_q   <= ctrl_d;
`ifdef DECODE_ILLEGAL_EN
      ill_q    <= ill_d;
`endif
    end
  end

  assign ex_valid  = valid_q;
  assign ex_pc     = pc_q;
  assign ex_ALUop  = aluop_q;
  assign ex_funct7 = funct7_q;
  assign ex_funct3 = funct3_q;
  assign ex_rs1    = rs1_q;
  assign ex_rs2    = rs2_q;
  assign ex_rd     = rd_q;
  assign ex_imm    = imm_q;
  assign ex_ctrl   = ctrl_q;
`ifdef DECODE_ILLEGAL_EN
  assign ex_illegal = ill_q;
`endif

endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed stimulus for id_decode_stage with an instruction-level reference model.
// The model keeps the last instruction handed to EX and derives every expected field from it.
// Literal checks after selected edges pin the model's interpretation of the decode rules.

module tb_id_decode_stage;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_pc    = 32'd0;
  logic        flush    = 1'b0;
  logic        ex_stall = 1'b0;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  ex_ALUop;
  logic [6:0]  ex_funct7;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [31:0] ex_imm;
  logic [5:0]  ex_ctrl;
`ifdef DECODE_ILLEGAL_EN
  logic        ex_illegal;
`endif

  id_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ALUop(ex_ALUop), .ex_funct7(ex_funct7),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl)
`ifdef DECODE_ILLEGAL_EN
    , .ex_illegal(ex_illegal)
`endif
  );

  always #5 clk = ~clk;

  // Instruction constants
  localparam logic [31:0] ADD3   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] SRAI4  = 32'h4030D213; // srai x4,x1,3
  localparam logic [31:0] LW5    = 32'h0080A283; // lw   x5,8(x1)
  localparam logic [31:0] ADD6   = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] SW     = 32'h0020A623; // sw   x2,12(x1)
  localparam logic [31:0] SW5    = 32'h0050A623; // sw   x5,12(x1)
  localparam logic [31:0] ADDI7  = 32'h00508393; // addi x7,x1,5
  localparam logic [31:0] BEQ8   = 32'h00208463; // beq  x1,x2,+8
  localparam logic [31:0] BNEM4  = 32'hFE209EE3; // bne  x1,x2,-4
  localparam logic [31:0] ADDIM1 = 32'hFFF00393; // addi x7,x0,-1
  localparam logic [31:0] LUI    = 32'h123452B7; // lui  x5,0x12345
  localparam logic [31:0] LW0    = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD000 = 32'h00000333; // add  x6,x0,x0

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {K_NONE, K_R, K_I, K_LD, K_ST, K_BR, K_BAD} kind_e;

  function automatic kind_e kind_of(input logic [31:0] ins);
    case (ins[6:0])
      7'h33:   return K_R;
      7'h13:   return K_I;
      7'h03:   return K_LD;
      7'h23:   return K_ST;
      7'h63:   return K_BR;
      default: return K_BAD;
    endcase
  endfunction

  function automatic int imm_of(input logic [31:0] ins);
    int v;
    v = 0;
    case (kind_of(ins))
      K_I, K_LD: begin
        v = int'(ins[31:20]);
        if (v >= 2048) v -= 4096;
      end
      K_ST: begin
        v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
        if (v >= 2048) v -= 4096;
      end
      K_BR: begin
        v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [5:0] ctrl_of(input kind_e k);
    logic branch, memtoreg, memwrite, memread, regwrite, alusrc;
    branch   = (k == K_BR);
    memtoreg = (k == K_LD);
    memwrite = (k == K_ST);
    memread  = (k == K_LD);
    regwrite = (k == K_R) || (k == K_I) || (k == K_LD);
    alusrc   = (k == K_I) || (k == K_LD) || (k == K_ST);
    return {branch, memtoreg, memwrite, memread, regwrite, alusrc};
  endfunction

  function automatic logic [1:0] aluop_of(input kind_e k);
    case (k)
      K_BR:    return 2'd1;
      K_R:     return 2'd2;
      K_I:     return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Model state: what sits in ID/EX (K_NONE = bubble)
  kind_e       m_kind  = K_NONE;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_pc    = 32'd0;
  logic        m_ill   = 1'b0;

  function automatic logic model_hazard();
    kind_e k;
    logic  uses2;
    k     = kind_of(in_instr);
    uses2 = (k == K_R) || (k == K_ST) || (k == K_BR);
    return (m_kind == K_LD) && (m_instr[11:7] != 5'd0) && in_valid &&
           ((in_instr[19:15] == m_instr[11:7]) || (uses2 && in_instr[24:20] == m_instr[11:7]));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_kind <= K_NONE;
      m_pc   <= 32'd0;
      m_ill  <= 1'b0;
    end else if (flush) begin
      m_kind <= K_NONE;
      m_ill  <= 1'b0;
    end else if (ex_stall) begin
      m_kind <= m_kind;
    end else if (model_hazard() || !in_valid) begin
      m_kind <= K_NONE;
      m_ill  <= 1'b0;
    end else if (kind_of(in_instr) == K_BAD) begin
      m_kind <= K_NONE;
`ifdef DECODE_ILLEGAL_EN
      m_ill  <= 1'b1;
      m_pc   <= in_pc;
`else
      m_ill  <= 1'b0;
`endif
    end else begin
      m_kind  <= kind_of(in_instr);
      m_instr <= in_instr;
      m_pc    <= in_pc;
      m_ill   <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, half a cycle after each edge
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(!ex_stall && !model_hazard()));
    chk("ex_valid", 32'(ex_valid), 32'(m_kind != K_NONE));
    chk("ex_ctrl",  32'(ex_ctrl),  32'(ctrl_of(m_kind)));
    chk("ex_ALUop", 32'(ex_ALUop), (m_kind == K_NONE) ? 32'd0 : 32'(aluop_of(m_kind)));
    chk("ex_rd",    32'(ex_rd),    (m_kind == K_NONE) ? 32'd0 : 32'(m_instr[11:7]));
    chk("ex_imm",   ex_imm,        (m_kind == K_NONE) ? 32'd0 : 32'(imm_of(m_instr)));
    if (m_kind != K_NONE) begin
      chk("ex_pc",     ex_pc,            m_pc);
      chk("ex_funct7", 32'(ex_funct7),   32'(m_instr[31:25]));
      chk("ex_funct3", 32'(ex_funct3),   32'(m_instr[14:12]));
      chk("ex_rs1",    32'(ex_rs1),      32'(m_instr[19:15]));
      chk("ex_rs2",    32'(ex_rs2),      32'(m_instr[24:20]));
    end
`ifdef DECODE_ILLEGAL_EN
    chk("ex_illegal", 32'(ex_illegal), 32'(m_ill));
    if (m_ill) chk("ex_pc_illegal", ex_pc, m_pc);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_ctrl",  32'(ex_ctrl),  32'd0);
    chk("rst_pc",    ex_pc,         32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    ex_stall = 1'b1;
    #1;
    chk("rst_ready_stall", 32'(in_ready), 32'd0);
    ex_stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // R-type
    drive(1'b1, ADD3, 32'h100);
    tick();
    chk("add_valid",  32'(ex_valid),  32'd1);
    chk("add_aluop",  32'(ex_ALUop),  32'd2);
    chk("add_funct3", 32'(ex_funct3), 32'd0);
    chk("add_funct7", 32'(ex_funct7), 32'd0);
    chk("add_rd",     32'(ex_rd),     32'd3);
    chk("add_ctrl",   32'(ex_ctrl),   32'b000010);
    chk("add_pc",     ex_pc,          32'h100);

    // I-type shift
    drive(1'b1, SRAI4, 32'h104);
    tick();
    chk("srai_aluop",  32'(ex_ALUop),  32'd3);
    chk("srai_funct7", 32'(ex_funct7), 32'h20);
    chk("srai_funct3", 32'(ex_funct3), 32'd5);
    chk("srai_imm",    ex_imm,         32'h00000403);
    chk("srai_ctrl",   32'(ex_ctrl),   32'b000011);

    // load-use hazard
    drive(1'b1, LW5, 32'h108);
    tick();
    chk("lw_ctrl", 32'(ex_ctrl), 32'b010111);
    chk("lw_imm",  ex_imm,       32'd8);
    drive(1'b1, ADD6, 32'h10C);
    #1;
    chk("hz_ready", 32'(in_ready), 32'd0);
    tick();
    chk("hz_bubble_valid", 32'(ex_valid), 32'd0);
    chk("hz_bubble_ctrl",  32'(ex_ctrl),  32'd0);
    chk("hz_ready_after",  32'(in_ready), 32'd1);
    tick();
    chk("hz_add_valid", 32'(ex_valid), 32'd1);
    chk("hz_add_rd",    32'(ex_rd),    32'd6);
    chk("hz_add_pc",    ex_pc,         32'h10C);

    // store held by ex_stall for three cycles
    drive(1'b1, SW, 32'h110);
    tick();
    chk("sw_ctrl", 32'(ex_ctrl), 32'b001001);
    chk("sw_imm",  ex_imm,       32'd12);
    ex_stall = 1'b1;
    drive(1'b1, ADDI7, 32'h114);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ctrl",  32'(ex_ctrl),  32'b001001);
      chk("stall_imm",   ex_imm,        32'd12);
      chk("stall_pc",    ex_pc,         32'h110);
      chk("stall_valid", 32'(ex_valid), 32'd1);
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    ex_stall = 1'b0;
    tick();
    chk("post_stall_pc",  ex_pc,        32'h114);
    chk("post_stall_imm", ex_imm,       32'd5);

    // branches and negative immediates
    drive(1'b1, BEQ8, 32'h118);
    tick();
    chk("beq_imm",   ex_imm,         32'd8);
    chk("beq_aluop", 32'(ex_ALUop),  32'd1);
    chk("beq_ctrl",  32'(ex_ctrl),   32'b100000);
    drive(1'b1, BNEM4, 32'h11C);
    tick();
    chk("bne_imm", ex_imm, 32'hFFFFFFFC);
    drive(1'b1, ADDIM1, 32'h120);
    tick();
    chk("addi_m1_imm", ex_imm, 32'hFFFFFFFF);

    // unsupported opcode and idle
    drive(1'b1, LUI, 32'h124);
    tick();
    chk("lui_valid", 32'(ex_valid), 32'd0);
    chk("lui_ctrl",  32'(ex_ctrl),  32'd0);
    drive(1'b0, 32'd0, 32'd0);
    tick();
    chk("idle_valid", 32'(ex_valid), 32'd0);

    // hazard boundaries
    drive(1'b1, LW5, 32'h128);
    tick();
    drive(1'b1, ADDI7, 32'h12C);
    #1;
    chk("itype_rs2field_ready", 32'(in_ready), 32'd1);
    drive(1'b1, SW5, 32'h12C);
    #1;
    chk("store_rs2_ready", 32'(in_ready), 32'd0);
    drive(1'b1, LW0, 32'h12C);
    #1;
    chk("lw0_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, ADD000, 32'h130);
    #1;
    chk("rd0_ready", 32'(in_ready), 32'd1);
    tick();

    // flush together with stall discards the offered add
    drive(1'b1, ADD3, 32'h200);
    tick();
    flush    = 1'b1;
    ex_stall = 1'b1;
    drive(1'b1, ADD3, 32'h204);
    tick();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_ctrl",  32'(ex_ctrl),  32'd0);
    flush    = 1'b0;
    ex_stall = 1'b0;

    // reset pulse in the middle of a hazard
    drive(1'b1, LW5, 32'h300);
    tick();
    drive(1'b1, ADD6, 32'h304);
    #1;
    chk("rh_ready_before", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("rh_valid", 32'(ex_valid), 32'd0);
    chk("rh_ctrl",  32'(ex_ctrl),  32'd0);
    chk("rh_rd",    32'(ex_rd),    32'd0);
    chk("rh_imm",   ex_imm,        32'd0);
    chk("rh_pc",    ex_pc,         32'd0);
    chk("rh_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    chk("rh_add_valid", 32'(ex_valid), 32'd1);
    chk("rh_add_rd",    32'(ex_rd),    32'd6);
    chk("rh_add_pc",    ex_pc,         32'h304);

    // reset pulse in the middle of a stall
    drive(1'b1, SW, 32'h400);
    tick();
    ex_stall = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    chk("rs_valid", 32'(ex_valid), 32'd0);
    chk("rs_ctrl",  32'(ex_ctrl),  32'd0);
    ex_stall = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rs_empty_valid", 32'(ex_valid), 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
ID_DECODE_STAGE -- requirements
Module: id_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and immediate width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  IF/ID holds an instruction.
REQ-005 in_ready  output  1  stage accepts the instruction this cycle.
REQ-006 in_instr  input  32  raw RV32I instruction.
REQ-007 in_pc  input  XLEN  PC of in_instr.
REQ-008 flush  input  1  squash ID/EX content (taken branch).
REQ-009 ex_stall  input  1  EX cannot accept; hold ID/EX.
REQ-010 ex_valid  output  1  ID/EX holds a real instruction.
REQ-011 ex_pc  output  XLEN  registered PC.
REQ-012 ex_ALUop  output  2  00 load/store add, 01 branch subtract, 10 R-type, 11 I-type ALU.
REQ-013 ex_funct7, ex_funct3  output  7, 3  instr[31:25], instr[14:12].
REQ-014 ex_rs1, ex_rs2, ex_rd  output  5 each  register indices.
REQ-015 ex_imm  output  XLEN  sign-extended immediate.
REQ-016 ex_ctrl  output  6  {Branch, MemtoReg, MemWrite, MemRead, RegWrite, ALUSrc}.
REQ-017 ex_illegal  output  1  unsupported opcode (present only with the macro; see REQ-032).

Function
REQ-018 Latency: an instruction accepted (in_valid && in_ready) at edge N SHALL appear on all ex_* outputs after edge N.
REQ-019 Opcode decode SHALL be: 0110011 -> ALUop 10, ctrl RegWrite; 0010011 -> 11, ALUSrc+RegWrite; 0000011 -> 00, ALUSrc+RegWrite+MemRead+MemtoReg; 0100011 -> 00, ALUSrc+MemWrite; 1100011 -> 01, Branch.
REQ-020 Immediate: I-type instr[31:20], S-type {instr[31:25],instr[11:7]}, B-type {instr[31],instr[7],instr[30:25],instr[11:8],0}, all sign-extended; R-type imm SHALL be 0.
REQ-021 Any other opcode SHALL load a bubble: ex_valid 0, ex_ctrl 0.
REQ-022 Load-use hazard: ID/EX holds a valid load with ex_rd != 0 AND ex_rd equals incoming rs1, or incoming rs2 for R/S/B types -> in_ready 0 and a bubble SHALL be loaded for exactly one cycle.
REQ-023 in_ready = !ex_stall && !hazard, combinational.
REQ-024 Update priority per edge: flush > ex_stall > hazard bubble > accept > idle bubble (in_valid 0).
REQ-025 flush SHALL load a bubble regardless of ex_stall and in_valid; the instruction offered that cycle is discarded.
REQ-026 ex_stall (no flush) SHALL hold every ID/EX output unchanged.
REQ-027 A bubble SHALL zero ex_ctrl, ex_ALUop, ex_rd, ex_imm and clear ex_valid; other fields are don't-care.

Reset
REQ-028 While reset is high, all ex_* outputs SHALL be 0, asynchronously.
REQ-029 Reset asserted mid-stall or mid-hazard SHALL discard the held instruction; the first edge after release behaves as from empty.
REQ-030 in_ready SHALL be 1 during reset unless ex_stall is high.

Configuration
REQ-031 Macro DECODE_ILLEGAL_EN SHALL control illegal-instruction reporting.
REQ-032 Defined: ex_illegal port exists; an unsupported opcode with in_valid SHALL register ex_illegal 1 with ex_pc, ex_valid 0, ex_ctrl 0; cleared by the next load, flush or reset. Undefined: port absent, unsupported opcodes become silent bubbles.

Verification
REQ-033 0x002081B3 (add x3,x1,x2) -> next cycle ALUop 10, funct3 0, funct7 0, rd 3, ctrl 000010, ex_valid 1.
REQ-034 0x4030D213 (srai x4,x1,3) -> ALUop 11, funct7 0x20, funct3 5, imm 0x00000403, ctrl 000011.
REQ-035 0x0080A283 (lw x5,8(x1)) then 0x00228333 (add x6,x5,x2) -> in_ready 0 one cycle, bubble, add appears one cycle late.
REQ-036 0x0020A623 (sw x2,12(x1)) with ex_stall high 3 cycles -> outputs frozen, ctrl 001001, imm 12; proceeds after release.
REQ-037 flush and ex_stall together with valid add offered -> ex_valid 0, ex_ctrl 0; reset pulse mid-hazard -> all outputs 0 immediately.
